vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between the display pixel-fetch path and a host (CPU/game logic) port that issues writes and reads.
- The display is the hard-real-time requester and is never denied or delayed.
- Host writes are buffered in a small FIFO and drain into idle memory slots. Host reads are serviced one at a time, and only after all earlier writes have drained.
- The block sits between the sync/pixel-generation chain and the frame-buffer BRAM, in the pixel clock domain.

---
 rtl/vga_pkg.sv | 16 +
 rtl/vram_wr_fifo.sv | 57 +++++
 rtl/vram_arbiter.sv | 140 ++++++++++++++
 tb/tb_vram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the frame-buffer path: VRAM geometry, display fetch
// latency and the host read state encoding.
package vga_pkg;

   localparam int H_RES    = 320;
   localparam int V_RES    = 240;
   localparam int ADDR_W   = 17;
   localparam int DATA_W   = 12;
   localparam int DISP_LAT = 3;

   localparam logic [1:0] H_IDLE  = 2'd0;
   localparam logic [1:0] H_PEND  = 2'd1;
   localparam logic [1:0] H_ISSUE = 2'd2;
   localparam logic [1:0] H_DATA  = 2'd3;

endpackage

// File: rtl/vram_wr_fifo.sv
// Host write buffer: synchronous FIFO with occupancy and registered full/empty.
module vram_wr_fifo #(
   parameter  int W     = 29,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);
   import vga_pkg::*;

   logic [W-1:0]     store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_nxt;

   assign head = store[rd_ptr];

   always_comb begin
      level_nxt = level;
      case ({push, pop})
         2'b10:   level_nxt = level + LVL_W'(1);
         2'b01:   level_nxt = level - LVL_W'(1);
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_nxt;
         full  <= (level_nxt == LVL_W'(DEPTH));
         empty <= (level_nxt == '0);
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch always wins, buffered host writes
// drain into idle slots, host reads issue only once the write buffer is empty.
//
// state   | meaning
// H_IDLE  | ready for a new host read
// H_PEND  | read latched, waiting for empty FIFO and no display request
// H_ISSUE | read command on the mem_* bus
// H_DATA  | RAM data arriving, returned as a dvalid pulse next cycle
module vram_arbiter #(
   parameter  int ADDR_W     = vga_pkg::ADDR_W,
   parameter  int DATA_W     = vga_pkg::DATA_W,
   parameter  int FIFO_DEPTH = 4,
   localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_data,
   input  logic              host_wr_valid,
   output logic              host_wr_ready,
   input  logic [ADDR_W-1:0] host_wr_addr,
   input  logic [DATA_W-1:0] host_wr_data,
   input  logic              host_rd_valid,
   output logic              host_rd_ready,
   input  logic [ADDR_W-1:0] host_rd_addr,
   output logic              host_rd_dvalid,
   output logic [DATA_W-1:0] host_rd_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [LVL_W-1:0]  wr_level
);
   import vga_pkg::*;

   logic [ADDR_W+DATA_W-1:0] head;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     push;
   logic                     sel_disp;
   logic                     sel_wr;
   logic                     sel_rd;
   logic [1:0]               h_state;
   logic [ADDR_W-1:0]        rd_addr_q;
   logic [DISP_LAT-2:0]      disp_pipe;

   assign host_wr_ready = !fifo_full;
   // Held low during the dvalid cycle so a new read lands the cycle after.
   assign host_rd_ready = (h_state == H_IDLE) && !host_rd_dvalid;
   assign push          = host_wr_valid && !fifo_full;

   assign sel_disp = disp_req;
   assign sel_wr   = !disp_req && !fifo_empty;
   assign sel_rd   = !disp_req && fifo_empty && (h_state == H_PEND);

   vram_wr_fifo #(
      .W     (ADDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({host_wr_addr, host_wr_data}),
      .pop       (sel_wr),
      .head      (head),
      .level     (wr_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= sel_disp || sel_wr || sel_rd;
         mem_we <= sel_wr;
         if (sel_disp) begin
            mem_addr  <= disp_addr;
            mem_wdata <= '0;
         end else if (sel_wr) begin
            {mem_addr, mem_wdata} <= head;
         end else if (sel_rd) begin
            mem_addr  <= rd_addr_q;
            mem_wdata <= '0;
         end else begin
            mem_addr  <= '0;
            mem_wdata <= '0;
         end
      end
   end

   // Display return path tracks the request through the mem stage and RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_pipe  <= '0;
         disp_valid <= 1'b0;
         disp_data  <= '0;
      end else begin
         disp_pipe  <= {disp_pipe[DISP_LAT-3:0], disp_req};
         disp_valid <= disp_pipe[DISP_LAT-2];
         if (disp_pipe[DISP_LAT-2]) disp_data <= mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_state        <= H_IDLE;
         rd_addr_q      <= '0;
         host_rd_dvalid <= 1'b0;
         host_rd_data   <= '0;
      end else begin
         host_rd_dvalid <= 1'b0;
         case (h_state)
            H_IDLE: begin
               if (host_rd_valid && host_rd_ready) begin
                  rd_addr_q <= host_rd_addr;
                  h_state   <= H_PEND;
               end
            end
            H_PEND: begin
               if (sel_rd) h_state <= H_ISSUE;
            end
            H_ISSUE: h_state <= H_DATA;
            H_DATA: begin
               host_rd_data   <= mem_rdata;
               host_rd_dvalid <= 1'b1;
               h_state        <= H_IDLE;
            end
            default: h_state <= H_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port RAM whose
// unwritten words read back as addr + 0x100.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        disp_req;
   logic [16:0] disp_addr;
   logic        disp_valid;
   logic [11:0] disp_data;
   logic        host_wr_valid;
   logic        host_wr_ready;
   logic [16:0] host_wr_addr;
   logic [11:0] host_wr_data;
   logic        host_rd_valid;
   logic        host_rd_ready;
   logic [16:0] host_rd_addr;
   logic        host_rd_dvalid;
   logic [11:0] host_rd_data;
   logic        mem_en;
   logic        mem_we;
   logic [16:0] mem_addr;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;
   logic [2:0]  wr_level;

   int n_cmp = 0;
   int n_err = 0;

   logic [11:0] ram     [256];
   logic        written [256];

   always #5 clk = ~clk;

   vram_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .disp_req       (disp_req),
      .disp_addr      (disp_addr),
      .disp_valid     (disp_valid),
      .disp_data      (disp_data),
      .host_wr_valid  (host_wr_valid),
      .host_wr_ready  (host_wr_ready),
      .host_wr_addr   (host_wr_addr),
      .host_wr_data   (host_wr_data),
      .host_rd_valid  (host_rd_valid),
      .host_rd_ready  (host_rd_ready),
      .host_rd_addr   (host_rd_addr),
      .host_rd_dvalid (host_rd_dvalid),
      .host_rd_data   (host_rd_data),
      .mem_en         (mem_en),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .wr_level       (wr_level)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr[7:0]]     <= mem_wdata;
            written[mem_addr[7:0]] <= 1'b1;
         end else if (written[mem_addr[7:0]] === 1'b1) begin
            mem_rdata <= ram[mem_addr[7:0]];
         end else begin
            mem_rdata <= 12'({4'h0, mem_addr[7:0]} + 12'h100);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_disp_valid"}, 32'(disp_valid), 0);
      chk({tag, "_disp_data"},  32'(disp_data), 0);
      chk({tag, "_rd_dvalid"},  32'(host_rd_dvalid), 0);
      chk({tag, "_rd_data"},    32'(host_rd_data), 0);
      chk({tag, "_mem_en"},     32'(mem_en), 0);
      chk({tag, "_mem_we"},     32'(mem_we), 0);
      chk({tag, "_mem_addr"},   32'(mem_addr), 0);
      chk({tag, "_mem_wdata"},  32'(mem_wdata), 0);
      chk({tag, "_wr_level"},   32'(wr_level), 0);
      chk({tag, "_wr_ready"},   32'(host_wr_ready), 1);
      chk({tag, "_rd_ready"},   32'(host_rd_ready), 1);
   endtask

   initial begin
      logic [16:0] drain_addr [4];
      logic [11:0] drain_data [4];

      rst           = 1'b1;
      disp_req      = 1'b0;
      disp_addr     = '0;
      host_wr_valid = 1'b0;
      host_wr_addr  = '0;
      host_wr_data  = '0;
      host_rd_valid = 1'b0;
      host_rd_addr  = '0;
      #1 rst = 1'b0;
      tick;
      tick;
      chk_idle("reset");
      rst = 1'b1;
      tick;

      // Reset while a read is on the bus
      host_rd_valid = 1'b1;
      host_rd_addr  = 17'h5;
      tick;
      host_rd_valid = 1'b0;
      chk("rst_rd_pend_ready", 32'(host_rd_ready), 0);
      tick;
      chk("rst_rd_issue_en",   32'(mem_en), 1);
      chk("rst_rd_issue_we",   32'(mem_we), 0);
      chk("rst_rd_issue_addr", 32'(mem_addr), 32'h5);
      rst = 1'b0;
      #1;
      chk("rst_async_en",    32'(mem_en), 0);
      chk("rst_async_ready", 32'(host_rd_ready), 1);
      tick;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("rst_rd_no_dvalid", 32'(host_rd_dvalid), 0);
      end
      chk_idle("rst_after");

      // Display streaming, fixed latency 3
      for (int c = 0; c < 12; c++) begin
         if (c >= 3 && c < 11) begin
            chk("stream_valid", 32'(disp_valid), 1);
            chk("stream_data",  32'(disp_data), 32'(32'h100 + c - 3));
         end else begin
            chk("stream_idle", 32'(disp_valid), 0);
         end
         disp_req  = (c < 8);
         disp_addr = 17'(c);
         tick;
      end

      // Writes fill the FIFO under display load, then drain back to back
      disp_req  = 1'b1;
      disp_addr = 17'h20;
      for (int i = 0; i < 4; i++) begin
         chk("load_wr_ready", 32'(host_wr_ready), 1);
         host_wr_valid = 1'b1;
         host_wr_addr  = 17'(32'h40 + i);
         host_wr_data  = 12'(32'h500 + i);
         tick;
      end
      host_wr_valid = 1'b0;
      chk("load_level_full", 32'(wr_level), 4);
      chk("load_ready_full", 32'(host_wr_ready), 0);
      chk("load_no_we",      32'(mem_we), 0);
      chk("load_disp_addr",  32'(mem_addr), 32'h20);
      tick;
      disp_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("drain_we",    32'(mem_we), 1);
         chk("drain_addr",  32'(mem_addr), 32'(32'h40 + i));
         chk("drain_wdata", 32'(mem_wdata), 32'(32'h500 + i));
         chk("drain_level", 32'(wr_level), 32'(3 - i));
      end
      tick;
      chk("drain_done_en",    32'(mem_en), 0);
      chk("drain_done_level", 32'(wr_level), 0);
      chk("drain_done_ready", 32'(host_wr_ready), 1);

      // Full boundary: pop in the same cycle does not open the FIFO
      disp_req  = 1'b1;
      disp_addr = 17'h20;
      for (int i = 0; i < 4; i++) begin
         host_wr_valid = 1'b1;
         host_wr_addr  = 17'(32'h50 + i);
         host_wr_data  = 12'(32'h600 + i);
         tick;
      end
      host_wr_addr = 17'h60;
      host_wr_data = 12'h777;
      disp_req     = 1'b0;
      chk("full_ready_pop", 32'(host_wr_ready), 0);
      chk("full_level_pop", 32'(wr_level), 4);
      tick;
      chk("full_next_level", 32'(wr_level), 3);
      chk("full_next_ready", 32'(host_wr_ready), 1);
      chk("full_next_we",    32'(mem_we), 1);
      chk("full_next_addr",  32'(mem_addr), 32'h50);
      disp_req = 1'b1;
      tick;
      chk("full_end_level", 32'(wr_level), 4);
      chk("full_end_ready", 32'(host_wr_ready), 0);
      host_wr_valid = 1'b0;
      disp_req      = 1'b0;
      drain_addr = '{17'h51, 17'h52, 17'h53, 17'h60};
      drain_data = '{12'h601, 12'h602, 12'h603, 12'h777};
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("wrap_we",    32'(mem_we), 1);
         chk("wrap_addr",  32'(mem_addr), 32'(drain_addr[i]));
         chk("wrap_wdata", 32'(mem_wdata), 32'(drain_data[i]));
      end
      tick;
      chk("wrap_level", 32'(wr_level), 0);
      chk("wrap_en",    32'(mem_en), 0);
      disp_req  = 1'b1;
      disp_addr = 17'h60;
      tick;
      disp_req = 1'b0;
      tick;
      tick;
      chk("wrap_rb_valid", 32'(disp_valid), 1);
      chk("wrap_rb_data",  32'(disp_data), 32'h777);
      tick;

      // Read after write: read waits for both buffered writes to drain
      host_wr_valid = 1'b1;
      host_wr_addr  = 17'h10;
      host_wr_data  = 12'h111;
      tick;
      chk("raw_r1_level", 32'(wr_level), 1);
      chk("raw_r1_en",    32'(mem_en), 0);
      chk("raw_r1_ready", 32'(host_rd_ready), 1);
      host_wr_data  = 12'hABC;
      host_rd_valid = 1'b1;
      host_rd_addr  = 17'h10;
      tick;
      chk("raw_r2_level", 32'(wr_level), 1);
      chk("raw_r2_we",    32'(mem_we), 1);
      chk("raw_r2_wdata", 32'(mem_wdata), 32'h111);
      chk("raw_r2_ready", 32'(host_rd_ready), 0);
      host_wr_valid = 1'b0;
      host_rd_valid = 1'b0;
      tick;
      chk("raw_r3_level", 32'(wr_level), 0);
      chk("raw_r3_we",    32'(mem_we), 1);
      chk("raw_r3_wdata", 32'(mem_wdata), 32'hABC);
      tick;
      chk("raw_r4_en",   32'(mem_en), 1);
      chk("raw_r4_we",   32'(mem_we), 0);
      chk("raw_r4_addr", 32'(mem_addr), 32'h10);
      tick;
      chk("raw_r5_dvalid", 32'(host_rd_dvalid), 0);
      tick;
      chk("raw_r6_dvalid", 32'(host_rd_dvalid), 1);
      chk("raw_r6_data",   32'(host_rd_data), 32'hABC);
      chk("raw_r6_ready",  32'(host_rd_ready), 0);
      tick;
      chk("raw_r7_dvalid", 32'(host_rd_dvalid), 0);
      chk("raw_r7_ready",  32'(host_rd_ready), 1);

      // Display pre-empts a pending read for five cycles
      host_rd_valid = 1'b1;
      host_rd_addr  = 17'h5;
      tick;
      host_rd_valid = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c >= 4 && c <= 8) begin
            chk("pre_disp_valid", 32'(disp_valid), 1);
            chk("pre_disp_data",  32'(disp_data), 32'(32'h130 + c - 4));
         end else begin
            chk("pre_disp_idle", 32'(disp_valid), 0);
         end
         if (c >= 2 && c <= 6) begin
            chk("pre_disp_en",   32'(mem_en), 1);
            chk("pre_disp_addr", 32'(mem_addr), 32'(32'h30 + c - 2));
         end else if (c == 7) begin
            chk("pre_rd_en",   32'(mem_en), 1);
            chk("pre_rd_addr", 32'(mem_addr), 32'h5);
         end else begin
            chk("pre_bus_idle", 32'(mem_en), 0);
         end
         chk("pre_no_we", 32'(mem_we), 0);
         if (c == 9) begin
            chk("pre_dvalid", 32'(host_rd_dvalid), 1);
            chk("pre_rdata",  32'(host_rd_data), 32'h105);
         end else begin
            chk("pre_no_dvalid", 32'(host_rd_dvalid), 0);
         end
         chk("pre_rd_ready", 32'(host_rd_ready), (c == 10) ? 1 : 0);
         disp_req  = (c <= 5);
         disp_addr = 17'(32'h30 + c - 1);
         tick;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
